// File: rtl/bip_control.sv
// BIP accumulator processor control unit.
// Owns PC/IR, sequences fetch/decode/execute and drives datapath controls.
module bip_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  output logic [10:0] pc_addr,
  output logic [1:0]  SelA,
  output logic        SelB,
  output logic        Op,
  output logic        WrAcc,
  output logic [10:0] operand,
  output logic [10:0] data_addr,
  output logic        WrRam,
  output logic        halted,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXECUTE,
    HALT
  } state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  state_t      state, state_nx;
  logic [10:0] pc, pc_nx;
  logic [15:0] ir, ir_nx;
  logic [31:0] cnt, cnt_nx;
  logic [4:0]  opc;

  assign opc         = ir[15:11];
  assign pc_addr     = pc;
  assign operand     = ir[10:0];
  assign data_addr   = ir[10:0];
  assign halted      = (state == HALT);
  assign cycle_count = cnt;

  // State, PC, IR and cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state sequencing, saturating cycle count.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = ir;
    cnt_nx   = cnt;
    if (state != HALT && cnt != 32'hFFFF_FFFF)
      cnt_nx = cnt + 32'd1;
    unique case (state)
      FETCH:  state_nx = DECODE;
      DECODE: begin
        ir_nx    = instruction;
        state_nx = EXECUTE;
      end
      EXECUTE: begin
        if (opc == OP_HLT) begin
          state_nx = HALT;
        end else begin
          state_nx = FETCH;
          pc_nx    = pc + 11'd1;
        end
      end
      HALT:   state_nx = HALT;
    endcase
  end

  // Datapath controls: live only in EXECUTE, forced low during reset.
  always_comb begin
    SelA  = 2'd0;
    SelB  = 1'b0;
    Op    = 1'b0;
    WrAcc = 1'b0;
    WrRam = 1'b0;
    if (state == EXECUTE && !rst) begin
      unique case (1'b1)
        (opc == OP_STO): WrRam = 1'b1;
        (opc == OP_LD): begin
          SelA  = 2'd0;
          WrAcc = 1'b1;
        end
        (opc == OP_LDI): begin
          SelA  = 2'd1;
          WrAcc = 1'b1;
        end
        (opc == OP_ADD): begin
          SelA  = 2'd2;
          WrAcc = 1'b1;
        end
        (opc == OP_ADDI): begin
          SelA  = 2'd2;
          SelB  = 1'b1;
          WrAcc = 1'b1;
        end
        (opc == OP_SUB): begin
          SelA  = 2'd2;
          Op    = 1'b1;
          WrAcc = 1'b1;
        end
        (opc == OP_SUBI): begin
          SelA  = 2'd2;
          SelB  = 1'b1;
          Op    = 1'b1;
          WrAcc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control.
// Models program memory, accumulator and data memory around the DUT.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b1;
  logic [15:0] instruction;
  logic [10:0] pc_addr;
  logic [1:0]  SelA;
  logic        SelB;
  logic        Op;
  logic        WrAcc;
  logic [10:0] operand;
  logic [10:0] data_addr;
  logic        WrRam;
  logic        halted;
  logic [31:0] cycle_count;

  logic [15:0] pmem [2048];
  logic [15:0] dmem [2048];
  logic [15:0] acc;
  logic [15:0] opb;
  int          n_wracc;
  int          n_wrram;
  int          run_len;
  int          max_run;
  logic [10:0] last_waddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bip_control dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .pc_addr     (pc_addr),
    .SelA        (SelA),
    .SelB        (SelB),
    .Op          (Op),
    .WrAcc       (WrAcc),
    .operand     (operand),
    .data_addr   (data_addr),
    .WrRam       (WrRam),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  // Synchronous-read program memory.
  always @(posedge clk) instruction <= pmem[pc_addr];

  function automatic logic [15:0] sext(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

  assign opb = SelB ? sext(operand) : dmem[data_addr];

  // Accumulator datapath, data memory and strobe statistics.
  always @(posedge clk) begin
    if (clr) begin
      acc     <= '0;
      n_wracc <= 0;
      n_wrram <= 0;
      run_len <= 0;
      max_run <= 0;
      last_waddr <= '0;
    end else begin
      if (WrAcc) begin
        n_wracc <= n_wracc + 1;
        run_len <= run_len + 1;
        if (run_len + 1 > max_run) max_run <= run_len + 1;
        case (SelA)
          2'd0:    acc <= dmem[data_addr];
          2'd1:    acc <= sext(operand);
          default: acc <= Op ? acc - opb : acc + opb;
        endcase
      end else begin
        run_len <= 0;
      end
      if (WrRam) begin
        n_wrram <= n_wrram + 1;
        last_waddr <= data_addr;
        dmem[data_addr] <= acc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [4:0] o,
                                      input logic [10:0] a);
    return {o, a};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin
      pmem[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
  endtask

  task automatic run_to_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    // Reset and immediate arithmetic
    clear_mem();
    pmem[0] = ins(5'd3, 11'd5);
    pmem[1] = ins(5'd5, 11'd3);
    pmem[2] = ins(5'd7, 11'd10);
    pmem[3] = ins(5'd0, 11'd0);
    do_reset();
    check("rst_pc", {21'd0, pc_addr}, 32'd0);
    check("rst_strobes", {27'd0, SelA, SelB, Op, WrAcc, WrRam}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_count", cycle_count, 32'd0);
    check("fetch_wracc", {31'd0, WrAcc}, 32'd0);
    @(negedge clk);
    check("decode_wracc", {31'd0, WrAcc}, 32'd0);
    check("decode_count", cycle_count, 32'd1);
    @(negedge clk);
    check("exec_wracc", {31'd0, WrAcc}, 32'd1);
    check("exec_sela", {30'd0, SelA}, 32'd1);
    check("exec_operand", {21'd0, operand}, 32'd5);
    run_to_halt(100);
    check("imm_acc", {16'd0, acc}, 32'h0000_FFFE);
    check("imm_wracc_n", n_wracc, 32'd3);
    check("imm_wracc_w", max_run, 32'd1);
    check("imm_count", cycle_count, 32'd12);
    check("imm_pc", {21'd0, pc_addr}, 32'd3);
    repeat (3) @(negedge clk);
    check("halt_frozen", cycle_count, 32'd12);
    check("halt_hold", {31'd0, halted}, 32'd1);

    // Memory round trip
    clear_mem();
    pmem[0] = ins(5'd3, 11'h07F);
    pmem[1] = ins(5'd1, 11'd4);
    pmem[2] = ins(5'd3, 11'd0);
    pmem[3] = ins(5'd4, 11'd4);
    pmem[4] = ins(5'd0, 11'd0);
    do_reset();
    run_to_halt(100);
    check("mem_wrram_n", n_wrram, 32'd1);
    check("mem_waddr", {21'd0, last_waddr}, 32'd4);
    check("mem_dmem4", {16'd0, dmem[4]}, 32'h007F);
    check("mem_acc", {16'd0, acc}, 32'h007F);
    check("mem_count", cycle_count, 32'd15);

    // Sign extension and memory subtract
    clear_mem();
    dmem[5] = 16'h0001;
    pmem[0] = ins(5'd3, 11'h400);
    pmem[1] = ins(5'd1, 11'd6);
    pmem[2] = ins(5'd6, 11'd5);
    pmem[3] = ins(5'd0, 11'd0);
    do_reset();
    run_to_halt(100);
    check("sx_ldi", {16'd0, dmem[6]}, 32'h0000_FC00);
    check("sx_sub", {16'd0, acc}, 32'h0000_FBFF);

    // Illegal opcode acts as NOP
    clear_mem();
    pmem[0] = ins(5'd3, 11'd1);
    pmem[1] = ins(5'b11111, 11'h7FF);
    pmem[2] = ins(5'd0, 11'd0);
    do_reset();
    run_to_halt(100);
    check("ill_wracc_n", n_wracc, 32'd1);
    check("ill_wrram_n", n_wrram, 32'd0);
    check("ill_acc", {16'd0, acc}, 32'd1);
    check("ill_pc", {21'd0, pc_addr}, 32'd2);
    check("ill_count", cycle_count, 32'd9);

    // PC wrap after 2048 instructions
    clear_mem();
    for (int i = 0; i < 2047; i++) pmem[i] = ins(5'b01000, 11'd0);
    pmem[2047] = ins(5'd3, 11'd9);
    do_reset();
    repeat (6144) @(negedge clk);
    check("wrap_pc", {21'd0, pc_addr}, 32'd0);
    check("wrap_acc", {16'd0, acc}, 32'd9);
    check("wrap_count", cycle_count, 32'd6144);
    check("wrap_halted", {31'd0, halted}, 32'd0);

    // Reset during ADDI execute
    clear_mem();
    pmem[0] = ins(5'd3, 11'd1);
    pmem[1] = ins(5'd5, 11'd2);
    pmem[2] = ins(5'd0, 11'd0);
    do_reset();
    repeat (5) @(negedge clk);
    check("mid_exec", {31'd0, WrAcc}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_gate", {31'd0, WrAcc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_pc", {21'd0, pc_addr}, 32'd0);
    check("mid_acc", {16'd0, acc}, 32'd1);
    check("mid_wracc_n", n_wracc, 32'd1);
    check("mid_count", cycle_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
